alu_32_core: RTL and testbench
==============================

// Module: alu_32_core
// PURPOSE
//  RV32IM integer execute-stage ALU. Decodes a raw 32-bit instruction word (OP and OP-IMM
//  opcodes) and applies it to two register operands. Produces a registered 32-bit result plus
//  zero/overflow/negative flags for the core's execute stage.
// PARAMETERS
//  WIDTH  32  datapath width; only 32 is supported (instruction field positions are RV32)
// PORTS
//  clk    in   1      clock, all state on rising edge
//  rst    in   1      synchronous active-high reset
//  a      in   WIDTH  rs1 operand
//  b      in   WIDTH  rs2 operand (ignored for OP-IMM)
//  inst   in   32     raw instruction word
//  out    out  WIDTH  result, registered
//  z      out  1      out==0, registered
//  v      out  1      signed overflow of ADD/ADDI/SUB, registered
//  n      out  1      out[WIDTH-1], registered
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: out=0, z=1, v=0, n=0.
//  - Timing: inputs sampled at each rising clk edge; out/z/v/n valid after that edge.
//    Latency is 1 cycle and the datapath is fully pipelined (new op every cycle).
//  - rst has priority over any op on the same edge. Reset mid-stream discards that cycle's result.
//  - Decode: opc=inst[6:0], f3=inst[14:12], f7=inst[31:25], imm=sext(inst[31:20]).
//  - OP (opc 0110011), f7=0000000:
//    - f3 000 ADD; 001 SLL; 010 SLT (signed); 011 SLTU.
//    - f3 100 XOR; 101 SRL; 110 OR; 111 AND.
//  - OP, f7=0100000: f3 000 SUB (a-b), f3 101 SRA.
//  - OP, f7=0000001 (M extension):
//    - f3 000 MUL (low 32 of product); 001 MULH (s x s, high); 010 MULHSU (s x u, high);
//      011 MULHU (u x u, high).
//    - f3 100 DIV (signed, truncating); 101 DIVU; 110 REM (sign of dividend); 111 REMU.
//  - OP-IMM (opc 0010011): the same f3 map, with imm in place of b.
//    - ADDI, SLTI, SLTIU (compares against sext imm as unsigned), XORI, ORI, ANDI.
//    - SLLI / SRLI: shamt = inst[24:20]. SRAI selected by inst[30]=1.
//  - Shift amounts use only the low 5 bits of b (R-type) or inst[24:20] (I-type).
//  - SLT/SLTU result is 0 or 1, zero-extended.
//  - Division corner cases:
//    - divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
//    - 0x80000000 / -1: DIV -> 0x80000000, REM -> 0.
//  - Flags:
//    - z = (out==0); n = out[31].
//    - v: ADD/ADDI = operands same sign and result sign differs; SUB = a,b signs differ and
//      result sign != a sign. v=0 for all other ops.
//  - Undefined opcode/funct combinations: out=0, z=1, v=0, n=0.
//  - Multiply and divide are combinational within the single cycle; no stall or handshake.
// TESTING
//  1. ADD a=0x7FFFFFFF b=0x7FFFFFFF -> out=0xFFFFFFFE v=1 n=1 z=0;
//     ADD 0x0101FFFF+0x0011FFFF -> 0x0113FFFE v=0.
//  2. SUB a=0 b=0x7FFFFFFF -> 0x80000001 n=1 v=0; SUB 0x0101FFFF-0x0101FFFF -> 0 z=1.
//  3. MUL 1*0x3321FFFF -> 0x3321FFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//     MULH 0xFFFFFFFF*0xFFFFFFFF -> 0.
//  4. Shifts:
//     - SLL 0x0871ABCD by 15 -> 0xD5E68000.
//     - SRL 0xFFFFFFFF by 10 -> 0x003FFFFF; SRA same -> 0xFFFFFFFF.
//     - SRAI 0xF871ABCD by 3 -> 0xFF0E3579.
//  5. Immediates:
//     - XORI 0xABCD4321 imm 0x44C -> 0xABCD476D.
//     - ADDI 5 imm 0xFFF -> 4.
//     - SLTI 0x0871ABCD imm 0x224 -> 0.
//     - ANDI 0x1234FFFF imm 0x44C -> 0x44C.
//  6. Division and reset:
//     - DIV by 0 -> 0xFFFFFFFF; REM 7 by 0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//     - rst=1 during ops -> next edge out=0 z=1.
//     - Every result appears exactly one edge after its inputs are applied.

Source files
------------

// File: rtl/alu_32_if.sv
// ---------------------------------------------------------------------------
// alu_32_if
// Operand/instruction/result bundle between the execute stage and the ALU.
//
// Signals
//   a     rs1 operand                       (master -> slave)
//   b     rs2 operand, unused by OP-IMM     (master -> slave)
//   inst  raw 32-bit RV32 instruction word  (master -> slave)
//   out   registered result                 (slave -> master)
//   z     out == 0                          (slave -> master)
//   v     signed overflow of ADD/ADDI/SUB   (slave -> master)
//   n     out sign bit                      (slave -> master)
//
// Modports
//   master  drives operands and instruction, observes result and flags
//   slave   the ALU itself
// ---------------------------------------------------------------------------
interface alu_32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [31:0]      inst;
    logic [WIDTH-1:0] out;
    logic             z;
    logic             v;
    logic             n;

    modport master (
        output a,
        output b,
        output inst,
        input  out,
        input  z,
        input  v,
        input  n
    );

    modport slave (
        input  a,
        input  b,
        input  inst,
        output out,
        output z,
        output v,
        output n
    );
endinterface

// File: rtl/alu_32_core.sv
// ---------------------------------------------------------------------------
// alu_32_core
// RV32IM execute-stage ALU. Decodes OP and OP-IMM instruction words, applies
// them to the rs1/rs2 operands and registers the 32-bit result together with
// zero, overflow and negative flags. One result per cycle, latency one edge.
// Multiply and divide are fully combinational; there is no stall path.
//
// Parameters
//   WIDTH  datapath width; only 32 works since RV32 field positions are fixed
//
// Ports
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset (out=0, z=1, v=0, n=0)
//   bus   alu_32_if slave: a, b, inst in; out, z, v, n out
// ---------------------------------------------------------------------------
module alu_32_core #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_32_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Instruction fields
    logic [6:0]     opc;
    logic [2:0]     f3;
    logic [6:0]     f7;
    logic [MSB:0]   imm;
    logic           isOp;
    logic           isOpImm;

    assign opc     = bus.inst[6:0];
    assign f3      = bus.inst[14:12];
    assign f7      = bus.inst[31:25];
    assign imm     = {{(WIDTH-12){bus.inst[31]}}, bus.inst[31:20]};
    assign isOp    = (opc == OPC_OP);
    assign isOpImm = (opc == OPC_OP_IMM);

    // Operand selection: OP-IMM substitutes the sign-extended immediate for
    // rs2, and its shift amount comes from the instruction rather than rs2.
    logic [MSB:0]   opA;
    logic [MSB:0]   opB;
    logic [4:0]     shamt;

    assign opA   = bus.a;
    assign opB   = isOpImm ? imm : bus.b;
    assign shamt = isOpImm ? bus.inst[24:20] : bus.b[4:0];

    // Base integer results
    logic [MSB:0]   sumRes;
    logic [MSB:0]   diffRes;
    logic           addOvf;
    logic           subOvf;
    logic           ltSigned;
    logic           ltUnsigned;
    logic [MSB:0]   sllRes;
    logic [MSB:0]   srlRes;
    logic [MSB:0]   sraRes;

    assign sumRes     = opA + opB;
    assign diffRes    = opA - bus.b;
    assign addOvf     = (opA[MSB] == opB[MSB]) && (sumRes[MSB] != opA[MSB]);
    assign subOvf     = (opA[MSB] != bus.b[MSB]) && (diffRes[MSB] != opA[MSB]);
    assign ltSigned   = $signed(opA) < $signed(opB);
    assign ltUnsigned = opA < opB;
    assign sllRes     = opA << shamt;
    assign srlRes     = opA >> shamt;
    assign sraRes     = $unsigned($signed(opA) >>> shamt);

    // One shared signed multiplier covers all four multiply flavours: each
    // operand is extended with either its sign bit or zero depending on
    // whether that side is treated as signed, so the 64-bit window of the
    // product is correct for MUL, MULH, MULHSU and MULHU alike.
    logic           mulASigned;
    logic           mulBSigned;
    logic signed [2*WIDTH+1:0] mulA;
    logic signed [2*WIDTH+1:0] mulB;
    logic signed [2*WIDTH+1:0] product;

    assign mulASigned = (f3 == 3'b001) || (f3 == 3'b010);
    assign mulBSigned = (f3 == 3'b001);
    assign mulA       = {{(WIDTH+2){mulASigned & opA[MSB]}}, opA};
    assign mulB       = {{(WIDTH+2){mulBSigned & bus.b[MSB]}}, bus.b};
    assign product    = mulA * mulB;

    // Divider works on magnitudes and fixes signs afterwards. The most
    // negative dividend over -1 falls out naturally: its magnitude is
    // 0x80000000, both signs are negative so no negation is applied, and the
    // remainder is zero. Division by zero is steered to a divisor of one so
    // the unused quotient never goes undefined, then overridden.
    logic           divSigned;
    logic           dividendNeg;
    logic           divisorNeg;
    logic           divByZero;
    logic [MSB:0]   absDividend;
    logic [MSB:0]   absDivisor;
    logic [MSB:0]   safeDivisor;
    logic [MSB:0]   quotMag;
    logic [MSB:0]   remMag;
    logic [MSB:0]   divRes;
    logic [MSB:0]   remRes;

    assign divSigned   = ~f3[0];
    assign dividendNeg = divSigned & opA[MSB];
    assign divisorNeg  = divSigned & bus.b[MSB];
    assign divByZero   = (bus.b == '0);
    assign absDividend = dividendNeg ? (~opA + 1'b1) : opA;
    assign absDivisor  = divisorNeg ? (~bus.b + 1'b1) : bus.b;
    assign safeDivisor = divByZero ? {{(WIDTH-1){1'b0}}, 1'b1} : absDivisor;
    assign quotMag     = absDividend / safeDivisor;
    assign remMag      = absDividend % safeDivisor;
    assign divRes      = divByZero ? '1
                       : ((dividendNeg ^ divisorNeg) ? (~quotMag + 1'b1) : quotMag);
    assign remRes      = divByZero ? opA
                       : (dividendNeg ? (~remMag + 1'b1) : remMag);

    // Decode: pick the result for legal OP / OP-IMM encodings. Anything not
    // recognised leaves legal low, which forces the all-zero result below.
    logic [MSB:0]   result;
    logic           legal;
    logic           ovf;

    always_comb begin
        result = '0;
        legal  = 1'b0;
        ovf    = 1'b0;
        if (isOp) begin
            case (f7)
                F7_BASE: begin
                    legal = 1'b1;
                    case (f3)
                        3'b000: begin
                            result = sumRes;
                            ovf    = addOvf;
                        end
                        3'b001: result = sllRes;
                        3'b010: result = {{(WIDTH-1){1'b0}}, ltSigned};
                        3'b011: result = {{(WIDTH-1){1'b0}}, ltUnsigned};
                        3'b100: result = opA ^ opB;
                        3'b101: result = srlRes;
                        3'b110: result = opA | opB;
                        default: result = opA & opB;
                    endcase
                end
                F7_ALT: begin
                    case (f3)
                        3'b000: begin
                            legal  = 1'b1;
                            result = diffRes;
                            ovf    = subOvf;
                        end
                        3'b101: begin
                            legal  = 1'b1;
                            result = sraRes;
                        end
                        default: legal = 1'b0;
                    endcase
                end
                F7_MEXT: begin
                    legal = 1'b1;
                    case (f3)
                        3'b000:  result = product[MSB:0];
                        3'b001,
                        3'b010,
                        3'b011:  result = product[2*WIDTH-1:WIDTH];
                        3'b100,
                        3'b101:  result = divRes;
                        default: result = remRes;
                    endcase
                end
                default: legal = 1'b0;
            endcase
        end else if (isOpImm) begin
            case (f3)
                3'b000: begin
                    legal  = 1'b1;
                    result = sumRes;
                    ovf    = addOvf;
                end
                3'b001: begin
                    legal  = (f7 == F7_BASE);
                    result = sllRes;
                end
                3'b010: begin
                    legal  = 1'b1;
                    result = {{(WIDTH-1){1'b0}}, ltSigned};
                end
                3'b011: begin
                    legal  = 1'b1;
                    result = {{(WIDTH-1){1'b0}}, ltUnsigned};
                end
                3'b100: begin
                    legal  = 1'b1;
                    result = opA ^ opB;
                end
                3'b101: begin
                    // Upper immediate bits select SRLI (0000000) or SRAI (0100000)
                    if (f7 == F7_BASE) begin
                        legal  = 1'b1;
                        result = srlRes;
                    end else if (f7 == F7_ALT) begin
                        legal  = 1'b1;
                        result = sraRes;
                    end
                end
                3'b110: begin
                    legal  = 1'b1;
                    result = opA | opB;
                end
                default: begin
                    legal  = 1'b1;
                    result = opA & opB;
                end
            endcase
        end
    end

    // Next-state values; flags are derived from the gated result so an
    // undefined encoding reads as a clean zero with z set.
    logic [MSB:0]   out_d;
    logic           z_d;
    logic           v_d;
    logic           n_d;

    assign out_d = legal ? result : '0;
    assign z_d   = (out_d == '0);
    assign v_d   = legal & ovf;
    assign n_d   = out_d[MSB];

    logic [MSB:0]   out_q;
    logic           z_q;
    logic           v_q;
    logic           n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            z_q   <= 1'b1;
            v_q   <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            out_q <= out_d;
            z_q   <= z_d;
            v_q   <= v_d;
            n_q   <= n_d;
        end
    end

    assign bus.out = out_q;
    assign bus.z   = z_q;
    assign bus.v   = v_q;
    assign bus.n   = n_q;

    // Register-index fields and the multiplier guard bits carry no meaning here
    logic unusedBits;
    assign unusedBits = ^{bus.inst[19:15], bus.inst[11:7], product[2*WIDTH+1:2*WIDTH]};

endmodule

// File: tb/tb_alu_32_core.sv
// ---------------------------------------------------------------------------
// tb_alu_32_core
// Self-checking bench for alu_32_core. A behavioural model computes each
// result from plain 64-bit arithmetic; a compare process checks every cycle
// one edge after inputs are sampled. Hand-computed vectors pin the model and
// the DUT, followed by a long run of randomised back-to-back operations with
// occasional resets.
// ---------------------------------------------------------------------------
module tb_alu_32_core;

    localparam longint MAX_S = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MIN_S = -64'sh0000_0000_8000_0000;

    logic clk;
    logic rst;

    alu_32_if #(.WIDTH(32)) bus ();

    alu_32_core #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [32:0] expNext;
    logic        armed = 1'b0;
    int          cycleNo = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record a comparison and report a failing one
    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: returns {v, out} for one instruction
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rhs;
        logic [31:0] y;
        logic [63:0] pu;
        logic [4:0]  sh;
        longint      sa;
        longint      sb;
        longint      t;
        logic        ovf;
        bit          isImm;
        opc   = inst[6:0];
        f3    = inst[14:12];
        f7    = inst[31:25];
        isImm = (opc == 7'b0010011);
        if (opc != 7'b0110011 && !isImm) return 33'd0;
        rhs = isImm ? {{20{inst[31]}}, inst[31:20]} : b;
        sa  = longint'($signed(a));
        sb  = longint'($signed(rhs));
        sh  = isImm ? inst[24:20] : b[4:0];
        ovf = 1'b0;
        y   = 32'd0;
        if (!isImm && f7 == 7'h01) begin
            case (f3)
                3'd0: begin t = sa * sb; y = t[31:0]; end
                3'd1: begin t = sa * sb; y = t[63:32]; end
                3'd2: begin t = sa * longint'({32'd0, b}); y = t[63:32]; end
                3'd3: begin pu = {32'd0, a} * {32'd0, b}; y = pu[63:32]; end
                3'd4: begin
                    if (b == 0) y = 32'hFFFF_FFFF;
                    else begin t = sa / sb; y = t[31:0]; end
                end
                3'd5: y = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 0) y = a;
                    else begin t = sa % sb; y = t[31:0]; end
                end
                default: y = (b == 0) ? a : a % b;
            endcase
            return {1'b0, y};
        end
        if (!isImm && f7 != 7'h00 && f7 != 7'h20) return 33'd0;
        if (!isImm && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) return 33'd0;
        case (f3)
            3'd0: begin
                t   = (!isImm && f7 == 7'h20) ? sa - sb : sa + sb;
                y   = t[31:0];
                ovf = (t > MAX_S) || (t < MIN_S);
            end
            3'd1: y = a << sh;
            3'd2: y = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: y = (a < rhs) ? 32'd1 : 32'd0;
            3'd4: y = a ^ rhs;
            3'd5: begin
                if (inst[30]) begin t = sa >>> sh; y = t[31:0]; end
                else y = a >> sh;
            end
            3'd6: y = a | rhs;
            default: y = a & rhs;
        endcase
        return {ovf, y};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] randInst();
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] w;
        int          k;
        k  = $urandom_range(0, 9);
        f3 = 3'($urandom_range(0, 7));
        if (k <= 4) begin
            case ($urandom_range(0, 9))
                0, 1, 2: f7 = 7'h00;
                3, 4:    f7 = 7'h20;
                5, 6, 7: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            return rtype(f7, f3);
        end else if (k <= 8) begin
            imm = 12'($urandom);
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return itype(imm, f3);
        end
        w      = $urandom;
        w[1:0] = 2'b00;
        return w;
    endfunction

    // Expected value for the coming edge, captured as the DUT samples
    initial begin
        forever begin
            @(posedge clk);
            expNext = rst ? 33'd0 : model(bus.a, bus.b, bus.inst);
            armed   = 1'b1;
        end
    end

    // Compare process: every cycle, one edge after inputs were sampled
    initial begin
        logic [31:0] expOut;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (armed) begin
                expOut = expNext[31:0];
                check($sformatf("pipe cycle %0d", cycleNo),
                      {29'd0, bus.out, bus.z, bus.v, bus.n},
                      {29'd0, expOut, (expOut == 32'd0), expNext[32], expOut[31]});
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst);
        @(posedge clk);
        #1;
        bus.a    = a;
        bus.b    = b;
        bus.inst = inst;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expOut, input logic expV);
        @(posedge clk);
        @(negedge clk);
        check(name, {29'd0, bus.out, bus.z, bus.v, bus.n},
              {29'd0, expOut, (expOut == 32'd0), expV, expOut[31]});
    endtask

    // Pin the model against a hand-computed value, then the DUT against it
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] inst, input logic [31:0] expOut, input logic expV);
        check({name, " model"}, {31'd0, model(a, b, inst)}, {31'd0, expV, expOut});
        applyStimulus(a, b, inst);
        checkOutput(name, expOut, expV);
    endtask

    initial begin
        rst      = 1'b1;
        bus.a    = 32'd0;
        bus.b    = 32'd0;
        bus.inst = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", {29'd0, bus.out, bus.z, bus.v, bus.n}, {29'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;

        directed("ADD ovf",   32'h7FFF_FFFF, 32'h7FFF_FFFF, rtype(7'h00, 3'd0), 32'hFFFF_FFFE, 1'b1);
        directed("ADD",       32'h0101_FFFF, 32'h0011_FFFF, rtype(7'h00, 3'd0), 32'h0113_FFFE, 1'b0);
        directed("SUB",       32'h0000_0000, 32'h7FFF_FFFF, rtype(7'h20, 3'd0), 32'h8000_0001, 1'b0);
        directed("SUB zero",  32'h0101_FFFF, 32'h0101_FFFF, rtype(7'h20, 3'd0), 32'h0000_0000, 1'b0);
        directed("SUB ovf",   32'h8000_0000, 32'h0000_0001, rtype(7'h20, 3'd0), 32'h7FFF_FFFF, 1'b1);
        directed("MUL",       32'h0000_0001, 32'h3321_FFFF, rtype(7'h01, 3'd0), 32'h3321_FFFF, 1'b0);
        directed("MULHU",     32'hFFFF_FFFF, 32'hFFFF_FFFF, rtype(7'h01, 3'd3), 32'hFFFF_FFFE, 1'b0);
        directed("MULH",      32'hFFFF_FFFF, 32'hFFFF_FFFF, rtype(7'h01, 3'd1), 32'h0000_0000, 1'b0);
        directed("MULHSU",    32'hFFFF_FFFF, 32'hFFFF_FFFF, rtype(7'h01, 3'd2), 32'hFFFF_FFFF, 1'b0);
        directed("SLL",       32'h0871_ABCD, 32'd15,        rtype(7'h00, 3'd1), 32'hD5E6_8000, 1'b0);
        directed("SRL",       32'hFFFF_FFFF, 32'd10,        rtype(7'h00, 3'd5), 32'h003F_FFFF, 1'b0);
        directed("SRA",       32'hFFFF_FFFF, 32'd10,        rtype(7'h20, 3'd5), 32'hFFFF_FFFF, 1'b0);
        directed("SLL amt5",  32'h0000_0001, 32'h0000_0021, rtype(7'h00, 3'd1), 32'h0000_0002, 1'b0);
        directed("SRAI",      32'hF871_ABCD, 32'hDEAD_BEEF, itype(12'h403, 3'd5), 32'hFF0E_3579, 1'b0);
        directed("XORI",      32'hABCD_4321, 32'h1111_1111, itype(12'h44C, 3'd4), 32'hABCD_476D, 1'b0);
        directed("ADDI",      32'h0000_0005, 32'h0000_0000, itype(12'hFFF, 3'd0), 32'h0000_0004, 1'b0);
        directed("SLTI",      32'h0871_ABCD, 32'hFFFF_FFFF, itype(12'h224, 3'd2), 32'h0000_0000, 1'b0);
        directed("SLTIU",     32'h0000_0001, 32'h0000_0000, itype(12'hFFF, 3'd3), 32'h0000_0001, 1'b0);
        directed("ANDI",      32'h1234_FFFF, 32'h0000_0000, itype(12'h44C, 3'd7), 32'h0000_044C, 1'b0);
        directed("SLT neg",   32'hFFFF_FFFF, 32'h0000_0001, rtype(7'h00, 3'd2), 32'h0000_0001, 1'b0);
        directed("SLTU neg",  32'hFFFF_FFFF, 32'h0000_0001, rtype(7'h00, 3'd3), 32'h0000_0000, 1'b0);
        directed("DIV by 0",  32'h0000_1234, 32'h0000_0000, rtype(7'h01, 3'd4), 32'hFFFF_FFFF, 1'b0);
        directed("DIVU by 0", 32'h0000_1234, 32'h0000_0000, rtype(7'h01, 3'd5), 32'hFFFF_FFFF, 1'b0);
        directed("REM by 0",  32'h0000_0007, 32'h0000_0000, rtype(7'h01, 3'd6), 32'h0000_0007, 1'b0);
        directed("REMU by 0", 32'h8000_0007, 32'h0000_0000, rtype(7'h01, 3'd7), 32'h8000_0007, 1'b0);
        directed("DIV ovf",   32'h8000_0000, 32'hFFFF_FFFF, rtype(7'h01, 3'd4), 32'h8000_0000, 1'b0);
        directed("REM ovf",   32'h8000_0000, 32'hFFFF_FFFF, rtype(7'h01, 3'd6), 32'h0000_0000, 1'b0);
        directed("DIV neg",   32'hFFFF_FFF9, 32'h0000_0002, rtype(7'h01, 3'd4), 32'hFFFF_FFFD, 1'b0);
        directed("REM neg",   32'hFFFF_FFF9, 32'h0000_0002, rtype(7'h01, 3'd6), 32'hFFFF_FFFF, 1'b0);
        directed("undef f7",  32'h0000_1234, 32'h0000_0001, rtype(7'h20, 3'd1), 32'h0000_0000, 1'b0);
        directed("undef opc", 32'h0000_1234, 32'h0000_0001, 32'h0000_0037,      32'h0000_0000, 1'b0);

        // Reset asserted alongside a live operation discards its result
        applyStimulus(32'h0000_0005, 32'h0000_0006, rtype(7'h00, 3'd0));
        rst = 1'b1;
        checkOutput("reset mid-stream", 32'h0000_0000, 1'b0);
        #1;
        rst = 1'b0;

        // Back-to-back randomised operations, checked every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 63) == 0);
            bus.a    = pickOperand();
            bus.b    = pickOperand();
            bus.inst = randInst();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
